// File: rtl/atahost_pio_tctrl.sv
// atahost_pio_tctrl: OCIDEC-1 PIO register-transfer timing engine.
// Generates ATA-3 PIO waveforms with snapshot timings and IORDY wait.
module atahost_pio_tctrl #(
  parameter int TWIDTH         = 8,
  parameter int PIO_mode0_T1   = 6,
  parameter int PIO_mode0_T2   = 28,
  parameter int PIO_mode0_T4   = 2,
  parameter int PIO_mode0_Teoc = 23
) (
  input  logic              clk,
  input  logic              arst_i,
  input  logic              rst,
  input  logic [TWIDTH-1:0] T1,
  input  logic [TWIDTH-1:0] T2,
  input  logic [TWIDTH-1:0] T4,
  input  logic [TWIDTH-1:0] Teoc,
  input  logic              IORDYen,
  input  logic              req,
  input  logic              we,
  input  logic [3:0]        a,
  input  logic [15:0]       d,
  output logic [15:0]       q,
  output logic              done,
  output logic              busy,
  output logic [2:0]        DA,
  output logic              CS0n,
  output logic              CS1n,
  output logic              DIORn,
  output logic              DIOWn,
  output logic [15:0]       DDo,
  output logic              DDoe,
  input  logic [15:0]       DDi,
  input  logic              IORDY
);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, EOC
  } state_t;

  state_t state, state_n;
  logic [TWIDTH-1:0] cnt, cnt_n;
  logic [TWIDTH-1:0] t2_r, t4_r, teoc_r;
  logic              we_r;
  logic [3:0]        a_r;
  logic [15:0]       d_r;
  logic              iordy_s1, iordy_s2;

  logic              cur_we;
  logic [3:0]        cur_a;
  logic [15:0]       cur_d;

  logic [15:0] q_n, ddo_n;
  logic [2:0]  da_n;
  logic        done_n, busy_n;
  logic        cs0_n, cs1_n, dior_n, diow_n, ddoe_n;

  // Transfer attributes come straight from the front end on the
  // launch edge, from the shadow copy afterwards.
  assign cur_we = (state == IDLE) ? we : we_r;
  assign cur_a  = (state == IDLE) ? a  : a_r;
  assign cur_d  = (state == IDLE) ? d  : d_r;

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      iordy_s1 <= 1'b1;
      iordy_s2 <= 1'b1;
    end else begin
      iordy_s1 <= IORDY;
      iordy_s2 <= iordy_s1;
    end
  end

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      state <= IDLE;
      cnt   <= TWIDTH'(PIO_mode0_T1);
    end else if (rst) begin
      state <= IDLE;
      cnt   <= TWIDTH'(PIO_mode0_T1);
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      t2_r   <= TWIDTH'(PIO_mode0_T2);
      t4_r   <= TWIDTH'(PIO_mode0_T4);
      teoc_r <= TWIDTH'(PIO_mode0_Teoc);
      we_r   <= 1'b0;
      a_r    <= '0;
      d_r    <= '0;
    end else if (state == IDLE && req && !rst) begin
      t2_r   <= T2;
      t4_r   <= T4;
      teoc_r <= Teoc;
      we_r   <= we;
      a_r    <= a;
      d_r    <= d;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt - TWIDTH'(1);
    unique case (state)
      IDLE: begin
        cnt_n = T1;
        if (req) state_n = SETUP;
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = STROBE;
          cnt_n   = t2_r;
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          if (IORDYen && !iordy_s2) begin
            cnt_n = '0;
          end else begin
            state_n = HOLD;
            cnt_n   = t4_r;
          end
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_n = EOC;
          cnt_n   = teoc_r;
        end
      end
      EOC: begin
        if (cnt == '0) begin
          state_n = IDLE;
          cnt_n   = T1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = T1;
      end
    endcase
  end

  // Pins are registered from the next state so they line up with it.
  always_comb begin
    da_n   = '0;
    cs0_n  = 1'b1;
    cs1_n  = 1'b1;
    dior_n = 1'b1;
    diow_n = 1'b1;
    ddo_n  = DDo;
    ddoe_n = 1'b0;
    done_n = 1'b0;
    busy_n = (state_n != IDLE);
    q_n    = q;
    if (state_n == SETUP || state_n == STROBE || state_n == HOLD) begin
      da_n  = cur_a[2:0];
      cs0_n = cur_a[3];
      cs1_n = !cur_a[3];
      if (cur_we) begin
        ddo_n  = cur_d;
        ddoe_n = 1'b1;
      end
    end
    if (state_n == STROBE) begin
      dior_n = cur_we;
      diow_n = !cur_we;
    end
    if (state_n == EOC) done_n = (cnt_n == '0);
    if (state == STROBE && state_n == HOLD && !we_r) q_n = DDi;
  end

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      DA    <= '0;
      CS0n  <= 1'b1;
      CS1n  <= 1'b1;
      DIORn <= 1'b1;
      DIOWn <= 1'b1;
      DDo   <= '0;
      DDoe  <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
      q     <= '0;
    end else if (rst) begin
      DA    <= '0;
      CS0n  <= 1'b1;
      CS1n  <= 1'b1;
      DIORn <= 1'b1;
      DIOWn <= 1'b1;
      DDo   <= '0;
      DDoe  <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
      q     <= '0;
    end else begin
      DA    <= da_n;
      CS0n  <= cs0_n;
      CS1n  <= cs1_n;
      DIORn <= dior_n;
      DIOWn <= diow_n;
      DDo   <= ddo_n;
      DDoe  <= ddoe_n;
      done  <= done_n;
      busy  <= busy_n;
      q     <= q_n;
    end
  end

endmodule

// File: tb/tb_atahost_pio_tctrl.sv
// tb_atahost_pio_tctrl: scoreboard bench for the PIO timing engine.
// Expected transfer shapes come from phase-length arithmetic.
module tb_atahost_pio_tctrl;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic arst_i, rst;
  logic [TW-1:0] T1, T2, T4, Teoc;
  logic IORDYen, req, we;
  logic [3:0] a;
  logic [15:0] d, q, DDo, DDi;
  logic done, busy;
  logic [2:0] DA;
  logic CS0n, CS1n, DIORn, DIOWn, DDoe, IORDY;

  always #5 clk = ~clk;

  atahost_pio_tctrl #(.TWIDTH(TW)) dut (
    .clk(clk), .arst_i(arst_i), .rst(rst),
    .T1(T1), .T2(T2), .T4(T4), .Teoc(Teoc),
    .IORDYen(IORDYen), .req(req), .we(we), .a(a), .d(d),
    .q(q), .done(done), .busy(busy),
    .DA(DA), .CS0n(CS0n), .CS1n(CS1n),
    .DIORn(DIORn), .DIOWn(DIOWn),
    .DDo(DDo), .DDoe(DDoe), .DDi(DDi), .IORDY(IORDY)
  );

  typedef struct {
    bit        abort;
    int        done_cyc;
    int        s_first;
    int        s_last;
    int        cs_last;
    bit        we;
    bit [3:0]  a;
    bit [15:0] d;
    bit [15:0] q;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [15:0] model_q;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit low(input int c, input int s, input int n);
    return n > 0 && c >= s && c < s + n;
  endfunction

  // Monitor: measures each busy window and compares with the queue head.
  bit act = 0;
  int cyc, m_dn, m_dc, m_sf, m_sl, m_csf, m_csl, m_oe, m_bad;
  bit m_rd, m_wr, m_cs0, m_cs1;
  logic [2:0] m_da;

  always @(negedge clk) begin
    if (busy) begin
      if (!act) begin
        act = 1; cyc = 0; m_dn = 0; m_dc = 0; m_sf = 0; m_sl = 0;
        m_csf = 0; m_csl = 0; m_oe = 0; m_bad = 0;
        m_rd = 0; m_wr = 0; m_cs0 = 0; m_cs1 = 0; m_da = '0;
      end
      cyc++;
      if (!DIORn || !DIOWn) begin
        if (m_sf == 0) m_sf = cyc;
        m_sl = cyc;
      end
      if (!DIORn) m_rd = 1;
      if (!DIOWn) m_wr = 1;
      if (!CS0n || !CS1n) begin
        if (m_csf == 0) m_csf = cyc;
        m_csl = cyc;
        m_da = DA;
      end
      if (!CS0n) m_cs0 = 1;
      if (!CS1n) m_cs1 = 1;
      if (DDoe) begin
        m_oe++;
        if (sb.size() > 0 && DDo !== sb[0].d) m_bad++;
      end
      if (done) begin
        m_dn++;
        m_dc = cyc;
      end
    end else if (act) begin
      act = 0;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty: got transfer expected none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.abort) begin
          chk("abort_no_done", m_dn, 0);
        end else begin
          chk("done_count", m_dn, 1);
          chk("done_cycle", m_dc, e.done_cyc);
          chk("strobe_first", m_sf, e.s_first);
          chk("strobe_last", m_sl, e.s_last);
          chk("cs_first", m_csf, 1);
          chk("cs_last", m_csl, e.cs_last);
          chk("da", m_da, e.a[2:0]);
          chk("cs0_sel", m_cs0, !e.a[3]);
          chk("cs1_sel", m_cs1, e.a[3]);
          chk("rd_strobe", m_rd, !e.we);
          chk("wr_strobe", m_wr, e.we);
          chk("ddoe_cycles", m_oe, e.we ? e.cs_last : 0);
          chk("ddo_value", m_bad, 0);
        end
        chk("q", q, e.q);
      end
    end
  end

  task automatic run(input int t1, t2, t4, teoc, input bit w,
                     input logic [3:0] ad, input logic [15:0] wd, dd,
                     input bit ioen, input int lo_s, lo_n,
                     input int t2n, rc, ac);
    exp_t e;
    int n, s, wt;
    bit stop;
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
    @(posedge clk); #1;
    T1 = TW'(t1); T2 = TW'(t2); T4 = TW'(t4); Teoc = TW'(teoc);
    we = w; a = ad; d = wd; DDi = dd; IORDYen = ioen; req = 1;
    s = t1 + t2 + 2;
    wt = 0;
    if (ioen) while (low(s + wt - 2, lo_s, lo_n)) wt++;
    e.abort = (rc > 0 || ac > 0);
    e.s_first = t1 + 2;
    e.s_last = s + wt;
    e.cs_last = s + wt + t4 + 1;
    e.done_cyc = e.cs_last + teoc + 1;
    e.we = w; e.a = ad; e.d = wd;
    if (e.abort) model_q = '0;
    else if (!w) model_q = dd;
    e.q = model_q;
    sb.push_back(e);
    @(posedge clk); #1;
    req = 0;
    stop = 0;
    for (int c = 1; c <= e.done_cyc + 3 && !stop; c++) begin
      IORDY = !low(c, lo_s, lo_n);
      if (c == 3 && t2n >= 0) begin
        T2 = TW'(t2n); a = ~a; d = ~d; we = ~we;
      end
      if (c == rc) rst = 1;
      if (c == ac) begin
        arst_i = 1;
        #2;
        chk("arst_busy", busy, 0);
        chk("arst_diorn", DIORn, 1);
        chk("arst_cs", {CS0n, CS1n}, 2'b11);
        chk("arst_q", q, 0);
        arst_i = 0;
        stop = 1;
      end
      @(posedge clk); #1;
      if (rst) begin
        rst = 0;
        chk("rst_busy", busy, 0);
        chk("rst_diorn", DIORn, 1);
        chk("rst_cs", {CS0n, CS1n}, 2'b11);
        chk("rst_done", done, 0);
        chk("rst_q", q, 0);
        chk("rst_ddoe", DDoe, 0);
        stop = 1;
      end
    end
    IORDY = 1;
  endtask

  initial begin
    arst_i = 1; rst = 0; req = 0; we = 0; a = '0; d = '0;
    T1 = 6; T2 = 28; T4 = 2; Teoc = 23; IORDYen = 0;
    DDi = '0; IORDY = 1; model_q = '0;
    #23;
    chk("rst_DIORn", DIORn, 1);
    chk("rst_DIOWn", DIOWn, 1);
    chk("rst_CS0n", CS0n, 1);
    chk("rst_CS1n", CS1n, 1);
    chk("rst_DA", DA, 0);
    chk("rst_DDo", DDo, 0);
    chk("rst_DDoe", DDoe, 0);
    chk("rst_q", q, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    #4 arst_i = 0;

    run(6, 28, 2, 23, 0, 4'h7, 16'h0000, 16'hA55A, 0, 0, 0, -1, 0, 0);
    run(1, 3, 1, 2, 1, 4'hE, 16'h1234, 16'h0F0F, 0, 0, 0, -1, 0, 0);
    run(0, 0, 0, 0, 0, 4'h3, 16'h0000, 16'h5AA5, 0, 0, 0, -1, 0, 0);
    run(2, 6, 1, 2, 0, 4'h1, 16'h0000, 16'hBEEF, 1, 6, 10, -1, 0, 0);
    run(2, 6, 1, 2, 0, 4'h1, 16'h0000, 16'hCAFE, 0, 6, 10, -1, 0, 0);
    run(6, 28, 2, 23, 0, 4'h2, 16'h0000, 16'h1111, 0, 0, 0, 3, 0, 0);
    run(6, 3, 2, 23, 1, 4'h9, 16'h4321, 16'h2222, 0, 0, 0, -1, 0, 0);
    run(2, 20, 1, 2, 0, 4'h5, 16'h0000, 16'h3333, 0, 0, 0, -1, 8, 0);
    run(2, 20, 1, 2, 0, 4'hB, 16'h0000, 16'h4444, 0, 0, 0, -1, 0, 8);
    run(1, 2, 1, 1, 0, 4'h4, 16'h0000, 16'h6789, 0, 0, 0, -1, 0, 0);

    for (int i = 0; i < 25; i++) begin
      run($urandom_range(0, 9), $urandom_range(0, 12),
          $urandom_range(0, 5), $urandom_range(0, 9),
          1'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
          1'($urandom), $urandom_range(1, 20), $urandom_range(0, 12),
          -1, 0, 0);
    end

    for (int n = 0; n < 200 && (sb.size() > 0 || busy); n++)
      @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
